vga_frame_pixel_source: RTL and testbench

- Self-contained 640x480@60 Hz VGA pixel source, one pixel clock.
- Generates horizontal/vertical sync and blanking, and walks a linear frame address over the visible area.
- Looks up an 8-bit colour index per pixel in a 307200-entry image ROM, then expands it to 24-bit colour through a 256-entry palette ROM.
- Sits between the pixel-clock PLL and the VGA DAC pins.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_sync_timing.sv | 32 +++
 rtl/vga_frame_pixel_source.sv | 64 ++++++
 tb/tb_vga_frame_pixel_source.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and shared types
package vga_timing_pkg;

  localparam int H_TOTAL   = 800;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 144;
  localparam int H_FRONT   = 16;
  localparam int V_TOTAL   = 525;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 34;
  localparam int V_FRONT   = 11;

  localparam int H_VISIBLE  = 640;
  localparam int V_VISIBLE  = 480;
  localparam int FRAME_SIZE = H_VISIBLE * V_VISIBLE;
  localparam int ADDR_W     = 19;

  localparam string IMG_INIT = "img_data.mif";
  localparam string PAL_INIT = "img_index.mif";

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [9:0]        cnt_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } sync_t;

endpackage

// File: rtl/vga_sync_timing.sv
// rtl/vga_sync_timing.sv - line/frame counters and stage-0 sync/blank generation
module vga_sync_timing
  import vga_timing_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  output sync_t sync
);

  cnt_t h_cnt;
  cnt_t v_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == cnt_t'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == cnt_t'(V_TOTAL - 1)) ? '0 : v_cnt + cnt_t'(1);
    end else begin
      h_cnt <= h_cnt + cnt_t'(1);
    end
  end

  always_comb begin
    sync.hs      = (h_cnt >= cnt_t'(H_SYNC));
    sync.vs      = (v_cnt >= cnt_t'(V_SYNC));
    sync.blank_n = (h_cnt >= cnt_t'(H_BACK)) && (h_cnt < cnt_t'(H_TOTAL - H_FRONT)) &&
                   (v_cnt >= cnt_t'(V_BACK)) && (v_cnt < cnt_t'(V_TOTAL - V_FRONT));
  end

endmodule

// File: rtl/vga_frame_pixel_source.sv
// rtl/vga_frame_pixel_source.sv - VGA source: frame address walk, image/palette ROMs, sync alignment
module vga_frame_pixel_source
  import vga_timing_pkg::*;
(
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  output logic       oHS,
  output logic       oVS,
  output logic       oBLANK_n,
  output logic [7:0] r_data,
  output logic [7:0] g_data,
  output logic [7:0] b_data
);

  sync_t       sync0;
  sync_t       sync1;
  sync_t       sync2;
  addr_t       addr;
  logic [7:0]  index;
  logic [23:0] bgr;

  logic [7:0]  img_rom [FRAME_SIZE];
  logic [23:0] pal_rom [256];

  vga_sync_timing u_timing (
    .clk   (iVGA_CLK),
    .rst_n (iRST_n),
    .sync  (sync0)
  );

  // Wrapping after the last pixel keeps the held address inside the image ROM
  // until the sync overlap clears it for the next frame.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      addr <= '0;
    end else if (!sync0.hs && !sync0.vs) begin
      addr <= '0;
    end else if (sync0.blank_n) begin
      addr <= (addr == addr_t'(FRAME_SIZE - 1)) ? '0 : addr + addr_t'(1);
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      index <= '0;
      bgr   <= '0;
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      index <= img_rom[addr];
      bgr   <= pal_rom[index];
      sync1 <= sync0;
      sync2 <= sync1;
    end
  end

  assign oHS      = sync2.hs;
  assign oVS      = sync2.vs;
  assign oBLANK_n = sync2.blank_n;
  assign b_data   = bgr[23:16];
  assign g_data   = bgr[15:8];
  assign r_data   = bgr[7:0];

endmodule

// File: tb/tb_vga_frame_pixel_source.sv
// tb/tb_vga_frame_pixel_source.sv - randomized self-checking bench for vga_frame_pixel_source
module tb_vga_frame_pixel_source;

  logic       clk;
  logic       rst_n;
  logic       hs, vs, blank_n;
  logic [7:0] r, g, b;

  int checks;
  int failures;
  int k;
  int phase;

  logic [7:0]  img_m [307200];
  logic [23:0] pal_m [256];

  logic        prev_hs, prev_blank;
  int          hs_low_run, blank_run, last_hs_rise, first_hs_rise, first_vs_rise;
  logic [26:0] got_v;

  localparam int PIX0_K = 2 + 34 * 800 + 144;

  vga_frame_pixel_source dut (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .oHS      (hs),
    .oVS      (vs),
    .oBLANK_n (blank_n),
    .r_data   (r),
    .g_data   (g),
    .b_data   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%h expected=%h", tag, k, got, exp);
    end
  endtask

  function automatic bit visible(input int h, input int v);
    return (h >= 144) && (h < 784) && (v >= 34) && (v < 514);
  endfunction

  // Visible pixels already passed in the current frame at raster position p.
  function automatic int vis_before(input int p);
    int h, v, rows, n;
    h    = p % 800;
    v    = (p / 800) % 525;
    rows = (v < 34) ? 0 : (v >= 514) ? 480 : v - 34;
    n    = rows * 640;
    if (v >= 34 && v < 514)
      n += (h < 144) ? 0 : (h >= 784) ? 640 : h - 144;
    return n % 307200;
  endfunction

  // Expected {hs, vs, blank_n, r, g, b} after kk rising edges since reset release.
  function automatic logic [26:0] exp_at(input int kk);
    int p, h, v;
    logic [23:0] c;
    if (kk < 1) return '0;
    if (kk == 1) begin
      c = pal_m[0];
      return {3'b000, c[7:0], c[15:8], c[23:16]};
    end
    p = kk - 2;
    h = p % 800;
    v = (p / 800) % 525;
    c = pal_m[img_m[vis_before(p)]];
    return {h >= 96, v >= 2, visible(h, v), c[7:0], c[15:8], c[23:16]};
  endfunction

  task automatic load_roms();
    for (int i = 0; i < 307200; i++) dut.img_rom[i] = img_m[i];
    for (int i = 0; i < 256; i++) dut.pal_rom[i] = pal_m[i];
  endtask

  task automatic clear_meas();
    k = 0;
    prev_hs = 1'b0;
    prev_blank = 1'b0;
    hs_low_run = 0;
    blank_run = 0;
    last_hs_rise = -1;
    first_hs_rise = -1;
    first_vs_rise = -1;
  endtask

  task automatic step(input bit do_check);
    @(negedge clk);
    k++;
    got_v = {hs, vs, blank_n, r, g, b};
    if (do_check) begin
      check("pixel_out", 32'(got_v), 32'(exp_at(k)));
      check("frame_addr", 32'(dut.addr), 32'(vis_before(k)));
    end
    if (phase == 1 && k == PIX0_K) begin
      check("pix0_rgb", 32'(got_v[23:0]), 32'h0);
      check("pix0_blank_edge", 32'({prev_blank, got_v[24]}), 32'b01);
    end
    if (phase == 1 && k == PIX0_K + 255) check("pix255_rgb", 32'(got_v[23:0]), 32'hFFFFFF);
    if (phase == 1 && k == PIX0_K + 256) check("pix256_rgb", 32'(got_v[23:0]), 32'h0);
    if (phase == 2 && k == 28800 + 2 + 144 + 10) check("pal5_rgb", 32'(got_v[23:0]), 32'hFF0000);
    if (got_v[26]) begin
      if (!prev_hs) begin
        if (first_hs_rise < 0) first_hs_rise = k;
        else begin
          check("hs_low_width", 32'(hs_low_run), 32'd96);
          check("hs_period", 32'(k - last_hs_rise), 32'd800);
        end
        last_hs_rise = k;
      end
      hs_low_run = 0;
    end else begin
      hs_low_run++;
    end
    if (got_v[24]) blank_run++;
    else begin
      if (prev_blank) check("blank_width", 32'(blank_run), 32'd640);
      blank_run = 0;
    end
    if (got_v[25] && first_vs_rise < 0) first_vs_rise = k;
    prev_hs = got_v[26];
    prev_blank = got_v[24];
  endtask

  initial begin
    checks = 0;
    failures = 0;
    phase = 1;
    clear_meas();
    rst_n = 1'b0;

    // Identity-grey palette, image index = low address byte.
    for (int i = 0; i < 307200; i++) img_m[i] = 8'(i);
    for (int i = 0; i < 256; i++) pal_m[i] = {8'(i), 8'(i), 8'(i)};
    load_roms();

    repeat (3) @(negedge clk);
    check("reset_out", 32'({hs, vs, blank_n, r, g, b}), 32'h0);
    check("reset_addr", 32'(dut.addr), 32'h0);
    rst_n = 1'b1;

    repeat (36 * 800) step(1'b1);
    check("first_hs_rise", 32'(first_hs_rise), 32'd98);
    check("first_vs_rise", 32'(first_vs_rise), 32'd1602);

    // Solid image of index 5 with palette entry 5 = pure red.
    phase = 2;
    for (int i = 0; i < 307200; i++) img_m[i] = 8'd5;
    for (int i = 0; i < 256; i++) pal_m[i] = 24'($urandom);
    pal_m[5] = 24'h0000FF;
    load_roms();
    repeat (2) step(1'b0);
    repeat (1600 - 2 + $urandom_range(0, 500)) step(1'b1);

    // Asynchronous reset mid-line, away from any clock edge.
    phase = 3;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", 32'({hs, vs, blank_n, r, g, b}), 32'h0);
    check("async_reset_addr", 32'(dut.addr), 32'h0);
    for (int i = 0; i < 307200; i++) img_m[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) pal_m[i] = 24'($urandom);
    load_roms();
    repeat (2) @(negedge clk);
    check("held_reset_out", 32'({hs, vs, blank_n, r, g, b}), 32'h0);
    clear_meas();
    rst_n = 1'b1;

    repeat (35 * 800 + $urandom_range(0, 400)) step(1'b1);
    check("restart_hs_rise", 32'(first_hs_rise), 32'd98);
    check("restart_vs_rise", 32'(first_vs_rise), 32'd1602);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
